// File: rtl/psum_requant_pkg.sv
// rtl/psum_requant_pkg.sv - shared sizes, fixed-point constants and state type for psum_requant
//
// Purpose: common definitions for the partial-sum requantizer.
//   `IFDATA_SIZE   : activation width, unsigned (8,7)
//   `WDATA_SIZE    : weight width
//   `MULT_OUT_SIZE : product width, signed (8,5)
//   MULT_FRAC / ACT_FRAC / REQ_SHIFT : fraction bits of product and activation
//   state_t        : ACCUM / HOLD
// Ports: none (package).

`ifndef IFDATA_SIZE
`define IFDATA_SIZE 8
`endif
`ifndef WDATA_SIZE
`define WDATA_SIZE 8
`endif
`ifndef MULT_OUT_SIZE
`define MULT_OUT_SIZE 8
`endif

package psum_requant_pkg;

  localparam int MULT_FRAC = 5;
  localparam int ACT_FRAC  = 7;
  localparam int REQ_SHIFT = ACT_FRAC - MULT_FRAC;

  // Largest positive sum that still fits the activation after the left shift.
  localparam int CLIP_LIM  = ((1 << `IFDATA_SIZE) - 1) >> REQ_SHIFT;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/psum_requant_sat_add.sv
// rtl/psum_requant_sat_add.sv - combinational saturating signed adder with overflow flag
//
// Purpose: sum = clamp(a + b) to the signed WIDTH-bit range; ovf marks a clamp.
// Ports:
//   a, b : signed WIDTH-bit operands
//   sum  : saturated signed result
//   ovf  : 1 when the true sum fell outside the representable range

module psum_requant_sat_add #(
  parameter int WIDTH = 16
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] sum,
  output logic                    ovf
);

  logic signed [WIDTH:0] full;

  always_comb begin
    full = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    // The extra bit disagrees with the sign bit exactly when the result overflowed.
    ovf  = full[WIDTH] ^ full[WIDTH-1];
    if (ovf) begin
      sum = full[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      sum = full[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/psum_requant.sv
// rtl/psum_requant.sv - accumulate signed products, ReLU and requantize to unsigned activations
//
// Purpose: sums cfg_len signed (8,5) products per group, then emits one
// ReLU'd unsigned (8,7) activation with a saturation flag.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   cfg_len              : terms per group, sampled on a group's first beat (0 means 1)
//   in_valid/in_ready    : product handshake; in_data is the signed product
//   out_valid/out_ready  : activation handshake; out_data, out_sat held while stalled

module psum_requant
  import psum_requant_pkg::*;
#(
  parameter int ACC_WIDTH = 16,
  parameter int LEN_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [LEN_WIDTH-1:0]      cfg_len,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [`MULT_OUT_SIZE-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [`IFDATA_SIZE-1:0]   out_data,
  output logic                      out_sat
);

  localparam logic signed [ACC_WIDTH-1:0] CLIP_S = ACC_WIDTH'(CLIP_LIM);
  localparam logic signed [ACC_WIDTH-1:0] ZERO_S = '0;

  state_t state, state_next;

  logic [LEN_WIDTH-1:0]        count;
  logic [LEN_WIDTH-1:0]        len_q;
  logic [LEN_WIDTH-1:0]        len_eff;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] ext;
  logic signed [ACC_WIDTH-1:0] add_a;
  logic signed [ACC_WIDTH-1:0] sum;
  logic                        ovf;
  logic                        sat_flag;
  logic                        sat_next;
  logic                        accept;
  logic                        first;
  logic                        last;
  logic [`IFDATA_SIZE-1:0]     q_data;
  logic                        q_clip;

  assign in_ready  = (state == ACCUM) && !rst;
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign first     = (count == '0);

  // The group length is live from cfg_len on the first beat so a one-term
  // group can finish on that same beat.
  assign len_eff = first ? ((cfg_len == '0) ? LEN_WIDTH'(1) : cfg_len) : len_q;
  assign last    = (count == len_eff - LEN_WIDTH'(1));

  assign ext   = ACC_WIDTH'($signed(in_data));
  // Adding to zero on the first beat restarts the sum and can never overflow.
  assign add_a = first ? ZERO_S : acc;

  psum_requant_sat_add #(
    .WIDTH(ACC_WIDTH)
  ) u_sat_add (
    .a  (add_a),
    .b  (ext),
    .sum(sum),
    .ovf(ovf)
  );

  assign sat_next = first ? ovf : (sat_flag | ovf);

  // ReLU, then shift up to the activation fraction with clipping at full scale.
  always_comb begin
    q_data = '0;
    q_clip = 1'b0;
    if (sum <= ZERO_S) begin
      q_data = '0;
    end else if (sum > CLIP_S) begin
      q_data = '1;
      q_clip = 1'b1;
    end else begin
      q_data = {sum[`IFDATA_SIZE-REQ_SHIFT-1:0], {REQ_SHIFT{1'b0}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ACCUM: if (accept && last) state_next = HOLD;
      HOLD:  if (out_ready)      state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      len_q    <= '0;
      acc      <= '0;
      sat_flag <= 1'b0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else if (accept) begin
      acc      <= sum;
      sat_flag <= sat_next;
      if (first) begin
        len_q <= len_eff;
      end
      if (last) begin
        count    <= '0;
        out_data <= q_data;
        out_sat  <= q_clip | sat_next;
      end else begin
        count <= count + LEN_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_psum_requant.sv
// tb/tb_psum_requant.sv - self-checking bench for psum_requant (16-bit and 10-bit accumulators)

module tb_psum_requant;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] cfg_len = 8'd0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       out_ready = 1'b1;

  logic       in_ready16, out_valid16, out_sat16;
  logic       in_ready10, out_valid10, out_sat10;
  logic [7:0] out_data16, out_data10;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  psum_requant #(.ACC_WIDTH(16), .LEN_WIDTH(8)) u16 (
    .clk(clk), .rst(rst), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready16), .in_data(in_data),
    .out_valid(out_valid16), .out_ready(out_ready),
    .out_data(out_data16), .out_sat(out_sat16)
  );

  psum_requant #(.ACC_WIDTH(10), .LEN_WIDTH(8)) u10 (
    .clk(clk), .rst(rst), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready10), .in_data(in_data),
    .out_valid(out_valid10), .out_ready(out_ready),
    .out_data(out_data10), .out_sat(out_sat10)
  );

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_terms[$];
  int m_len = 1;
  bit m_hold = 1'b0;
  int e_d16 = 0, e_s16 = 0, e_d10 = 0, e_s10 = 0;

  function automatic void reduce(input int w, output int d, output int s);
    longint mx = (longint'(1) << (w - 1)) - 1;
    longint mn = -mx - 1;
    longint a = 0;
    bit f = 1'b0;
    foreach (m_terms[i]) begin
      if (i == 0) a = m_terms[i];
      else begin
        a = a + m_terms[i];
        if (a > mx) begin a = mx; f = 1'b1; end
        else if (a < mn) begin a = mn; f = 1'b1; end
      end
    end
    if (a <= 0) begin d = 0; s = int'(f); end
    else if (a * 4 > 255) begin d = 255; s = 1; end
    else begin d = int'(a * 4); s = int'(f); end
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_hold = 1'b0;
      m_terms.delete();
    end else if (m_hold) begin
      if (out_ready) m_hold = 1'b0;
    end else if (in_valid) begin
      if (m_terms.size() == 0) m_len = (cfg_len == 8'd0) ? 1 : int'(cfg_len);
      m_terms.push_back(int'($signed(in_data)));
      if (m_terms.size() == m_len) begin
        reduce(16, e_d16, e_s16);
        reduce(10, e_d10, e_s10);
        m_hold = 1'b1;
        m_terms.delete();
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready16", in_ready16, int'(!m_hold && !rst));
    chk("in_ready10", in_ready10, int'(!m_hold && !rst));
    chk("out_valid16", out_valid16, int'(m_hold));
    chk("out_valid10", out_valid10, int'(m_hold));
    if (m_hold) begin
      chk("out_data16", out_data16, e_d16);
      chk("out_sat16", out_sat16, e_s16);
      chk("out_data10", out_data10, e_d10);
      chk("out_sat10", out_sat10, e_s10);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic send(input int v, input int len);
    int n;
    bit ok;
    n = 0;
    ok = 1'b0;
    cfg_len = 8'(len);
    in_data = 8'(v);
    in_valid = 1'b1;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = in_ready16;
      @(posedge clk);
      #1;
      n++;
    end
    chk("send_accept", ok, 1);
    in_valid = 1'b0;
  endtask

  task automatic get(input string name, input int max_wait,
                     input int d16, input int s16, input int d10, input int s10);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid16 && n < max_wait) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_valid"}, out_valid16, 1);
    chk({name, "_d16"}, out_data16, d16);
    chk({name, "_s16"}, out_sat16, s16);
    chk({name, "_d10"}, out_data10, d10);
    chk({name, "_s10"}, out_sat10, s10);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int r, v;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready16, 0);
    chk("rst_out_valid", out_valid16, 0);
    chk("rst_out_data", out_data16, 0);
    chk("rst_out_sat", out_sat16, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 0.25 + 0.125 = 0.375 -> 48, valid right after the last accept
    send(8, 2); send(4, 2);
    get("sum_small", 0, 48, 0, 48, 0);

    // sum 2.0 clips high
    repeat (4) send(16, 4);
    get("clip_high", 5, 255, 1, 255, 1);

    // negative sum -> ReLU, no flag
    send(-20, 2); send(5, 2);
    get("relu", 5, 0, 0, 0, 0);

    // five beats of 127: 10-bit accumulator clamps at 511
    repeat (5) send(127, 5);
    get("acc_clamp", 5, 255, 1, 255, 1);

    // positive clamp then pull back: 10-bit ends at -1 but keeps the flag
    repeat (5) send(127, 9);
    repeat (4) send(-128, 9);
    get("pos_sat_relu", 5, 255, 1, 0, 1);

    // negative clamp then pull back
    repeat (5) send(-128, 9);
    repeat (4) send(127, 9);
    get("neg_sat_relu", 5, 0, 0, 0, 1);

    // stalled output holds, input blocked
    out_ready = 1'b0;
    send(10, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid16, 1);
      chk("hold_data", out_data16, 40);
      chk("hold_in_ready", in_ready16, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("release_in_ready", in_ready16, 1);
    chk("release_valid", out_valid16, 0);
    @(posedge clk);
    #1;

    // reset mid-group discards the partial sum
    send(8, 3); send(8, 3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", out_valid16, 0);
    send(4, 1);
    get("after_rst", 0, 16, 0, 16, 0);

    // cfg_len 0 behaves as 1
    send(12, 0);
    get("len_zero", 0, 48, 0, 48, 0);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      r = int'($urandom % 4);
      if (r == 0) v = int'($urandom % 256) - 128;
      else v = int'($urandom_range(0, 50)) - 20;
      in_data = 8'(v);
      in_valid = ($urandom % 3) != 0;
      cfg_len = ($urandom % 8 == 0) ? 8'($urandom_range(0, 12)) : 8'($urandom_range(0, 5));
      out_ready = ($urandom % 2) != 0;
      rst = ($urandom % 250) == 0;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
